// File: rtl/multiport_ram_2w2r.sv
// -----------------------------------------------------------------------------
// multiport_ram_2w2r
//
// Two-write / two-read RAM built from one storage bank per write port and a
// live-value table (LVT). Each LVT entry records which bank holds the current
// value of that address, plus a flag saying the value came from a same-address
// write collision (both write ports hit the address in one cycle; port 1 wins).
//
// Optional feature macro: MPRAM_READ_COLLISION_EN
//   undefined (default): every bank is replicated once per reader, so both
//                        readers are always served and rdcollision[0] is 0.
//   defined            : every bank has a single read port shared through a
//                        read switch; when both readers need the same bank at
//                        different addresses, reader 1 is served and reader 2
//                        holds its data and reports rdcollision2[0] = 1.
//
// Parameters
//   ADDR_WIDTH      address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH      word width
//   WRITE_COLLISION 1 = track same-address write collisions, 0 = do not
//
// Ports
//   aclk                      clock, rising edge
//   aresetn                   synchronous active-low reset (LVT and read
//                             outputs only; bank contents are kept)
//   wren1/2, wraddr1/2, wrdata1/2   write ports 1 and 2
//   rden1/2, rdaddr1/2              read ports 1 and 2
//   rddata1/2                 read data, one cycle after rden, held otherwise
//   rdcollision1/2            bit0 = read not served (bank conflict)
//                             bit1 = word was last written under a collision
// -----------------------------------------------------------------------------
module multiport_ram_2w2r #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int WRITE_COLLISION = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wren1,
    input  logic [ADDR_WIDTH-1:0] wraddr1,
    input  logic [DATA_WIDTH-1:0] wrdata1,
    input  logic                  wren2,
    input  logic [ADDR_WIDTH-1:0] wraddr2,
    input  logic [DATA_WIDTH-1:0] wrdata2,
    input  logic                  rden1,
    input  logic [ADDR_WIDTH-1:0] rdaddr1,
    input  logic                  rden2,
    input  logic [ADDR_WIDTH-1:0] rdaddr2,
    output logic [DATA_WIDTH-1:0] rddata1,
    output logic [DATA_WIDTH-1:0] rddata2,
    output logic [1:0]            rdcollision1,
    output logic [1:0]            rdcollision2
);

    localparam int   DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic TRACK_COLL = (WRITE_COLLISION != 0);

    // Per-port views as arrays so the bank/reader generate loops can index them.
    // Enables are masked by reset so nothing is written or read while in reset.
    logic                  wr_en   [2];
    logic [ADDR_WIDTH-1:0] wr_addr [2];
    logic [DATA_WIDTH-1:0] wr_data [2];
    logic                  rd_en   [2];
    logic [ADDR_WIDTH-1:0] rd_addr [2];

    assign wr_en[0]   = wren1 & aresetn;
    assign wr_en[1]   = wren2 & aresetn;
    assign wr_addr[0] = wraddr1;
    assign wr_addr[1] = wraddr2;
    assign wr_data[0] = wrdata1;
    assign wr_data[1] = wrdata2;
    assign rd_en[0]   = rden1 & aresetn;
    assign rd_en[1]   = rden2 & aresetn;
    assign rd_addr[0] = rdaddr1;
    assign rd_addr[1] = rdaddr2;

    // -------------------------------------------------------------------------
    // Live-value table: bank select (0 = bank 1, 1 = bank 2) and collision flag.
    // Kept in flops because reset must clear every entry at once.
    // -------------------------------------------------------------------------
    logic lvt_bank_reg [DEPTH];
    logic lvt_coll_reg [DEPTH];
    logic wr_same_addr;

    assign wr_same_addr = wren1 & wren2 & (wraddr1 == wraddr2);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvt_bank_reg[i] <= 1'b0;
                lvt_coll_reg[i] <= 1'b0;
            end
        end else begin
            // Port 2 is applied first so port 1 overrides it on a shared address.
            if (wren2) begin
                lvt_bank_reg[wraddr2] <= 1'b1;
                lvt_coll_reg[wraddr2] <= 1'b0;
            end
            if (wren1) begin
                lvt_bank_reg[wraddr1] <= 1'b0;
                lvt_coll_reg[wraddr1] <= wr_same_addr & TRACK_COLL;
            end
        end
    end

    // LVT lookup for each reader, taken from the pre-edge table contents.
    logic rd_bank     [2];
    logic rd_flag     [2];
    logic rd_conflict [2];
    logic rd_served   [2];

    assign rd_bank[0] = lvt_bank_reg[rdaddr1];
    assign rd_bank[1] = lvt_bank_reg[rdaddr2];
    assign rd_flag[0] = lvt_coll_reg[rdaddr1];
    assign rd_flag[1] = lvt_coll_reg[rdaddr2];

`ifdef MPRAM_READ_COLLISION_EN
    // Single bank read port: reader 2 loses when it needs the bank reader 1 is
    // using at a different address. Identical addresses share the one read.
    assign rd_conflict[0] = 1'b0;
    assign rd_conflict[1] = rd_en[0] & rd_en[1] & (rd_bank[0] == rd_bank[1])
                          & (rd_addr[0] != rd_addr[1]);
`else
    assign rd_conflict[0] = 1'b0;
    assign rd_conflict[1] = 1'b0;
`endif

    assign rd_served[0] = rd_en[0] & ~rd_conflict[0];
    assign rd_served[1] = rd_en[1] & ~rd_conflict[1];

    // -------------------------------------------------------------------------
    // Storage banks. bank_rdata[bank][reader] is the registered word a reader
    // sees from a bank; with the read switch both readers share one register.
    // The array initialiser is the configuration-time value (all zeros); reset
    // never touches the banks.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] bank_rdata [2][2];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
`ifdef MPRAM_READ_COLLISION_EN
            logic                  sw_en;
            logic [ADDR_WIDTH-1:0] sw_addr;
            logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
            logic [DATA_WIDTH-1:0] rd_word_reg;

            // Read switch: reader 1 has priority on this bank's only read port.
            always_comb begin
                sw_en   = 1'b0;
                sw_addr = rd_addr[1];
                if (rd_en[0] && (rd_bank[0] == 1'(gi))) begin
                    sw_en   = 1'b1;
                    sw_addr = rd_addr[0];
                end else if (rd_en[1] && (rd_bank[1] == 1'(gi))) begin
                    sw_en   = 1'b1;
                    sw_addr = rd_addr[1];
                end
            end

            always_ff @(posedge aclk) begin
                if (wr_en[gi]) begin
                    mem[wr_addr[gi]] <= wr_data[gi];
                end
                if (sw_en) begin
                    rd_word_reg <= mem[sw_addr];
                end
            end

            for (gj = 0; gj < 2; gj++) begin : g_share
                assign bank_rdata[gi][gj] = rd_word_reg;
            end
`else
            // One copy of the bank per reader; all copies take the same writes.
            for (gj = 0; gj < 2; gj++) begin : g_copy
                logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
                logic [DATA_WIDTH-1:0] rd_word_reg;

                always_ff @(posedge aclk) begin
                    if (wr_en[gi]) begin
                        mem[wr_addr[gi]] <= wr_data[gi];
                    end
                    if (rd_en[gj] && (rd_bank[gj] == 1'(gi))) begin
                        rd_word_reg <= mem[rd_addr[gj]];
                    end
                end

                assign bank_rdata[gi][gj] = rd_word_reg;
            end
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Reader outputs. A served read shows the bank word selected at issue
    // time; otherwise the reader shows hold_reg, a copy of its previous output,
    // so data stays put even when the shared bank register is reused.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_out    [2];
    logic [1:0]            rd_status [2];

    generate
        for (gj = 0; gj < 2; gj++) begin : g_reader
            logic                  served_reg;
            logic                  sel_reg;
            logic [DATA_WIDTH-1:0] hold_reg;
            logic [1:0]            status_reg;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    served_reg <= 1'b0;
                    sel_reg    <= 1'b0;
                    hold_reg   <= '0;
                    status_reg <= 2'b00;
                end else begin
                    served_reg <= rd_served[gj];
                    sel_reg    <= rd_bank[gj];
                    hold_reg   <= rd_out[gj];
                    status_reg <= {rd_served[gj] & rd_flag[gj] & TRACK_COLL,
                                   rd_conflict[gj]};
                end
            end

            assign rd_out[gj]    = served_reg ? bank_rdata[sel_reg][gj] : hold_reg;
            assign rd_status[gj] = status_reg;
        end
    endgenerate

    assign rddata1      = rd_out[0];
    assign rddata2      = rd_out[1];
    assign rdcollision1 = rd_status[0];
    assign rdcollision2 = rd_status[1];

endmodule

// File: tb/tb_multiport_ram_2w2r.sv
// -----------------------------------------------------------------------------
// tb_multiport_ram_2w2r
//
// Directed vector table, a hand-written reset sequence, then random traffic
// compared against a bank/owner/flag reference model. Honours
// MPRAM_READ_COLLISION_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multiport_ram_2w2r;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam bit WC    = 1'b1;
`ifdef MPRAM_READ_COLLISION_EN
    localparam bit RD_SWITCH = 1'b1;
`else
    localparam bit RD_SWITCH = 1'b0;
`endif

    logic          aclk;
    logic          aresetn;
    logic          wren1, wren2, rden1, rden2;
    logic [AW-1:0] wraddr1, wraddr2, rdaddr1, rdaddr2;
    logic [DW-1:0] wrdata1, wrdata2;
    logic [DW-1:0] rddata1, rddata2;
    logic [1:0]    rdcollision1, rdcollision2;

    multiport_ram_2w2r #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .WRITE_COLLISION (1)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .wren1        (wren1),
        .wraddr1      (wraddr1),
        .wrdata1      (wrdata1),
        .wren2        (wren2),
        .wraddr2      (wraddr2),
        .wrdata2      (wrdata2),
        .rden1        (rden1),
        .rdaddr1      (rdaddr1),
        .rden2        (rden2),
        .rdaddr2      (rdaddr2),
        .rddata1      (rddata1),
        .rddata2      (rddata2),
        .rdcollision1 (rdcollision1),
        .rdcollision2 (rdcollision2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic          rst_n;
        logic          w1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          w2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        logic          r1;
        logic [AW-1:0] ra1;
        logic          r2;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e_rd1;
        logic [1:0]    e_c1;
        logic [DW-1:0] e_rd2;
        logic [1:0]    e_c2;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: contents of each bank, which write port owns each
    // address, and whether that ownership came from a same-address collision.
    logic [DW-1:0] m_bank  [2][DEPTH];
    int            m_owner [DEPTH];
    bit            m_coll  [DEPTH];
    logic [DW-1:0] m_rd    [2];
    logic [1:0]    m_col   [2];

    function automatic vec_t mk(input bit rst_n,
                                input bit w1, input int wa1, input int wd1,
                                input bit w2, input int wa2, input int wd2,
                                input bit r1, input int ra1,
                                input bit r2, input int ra2,
                                input int e_rd1, input int e_c1,
                                input int e_rd2, input int e_c2);
        vec_t v;
        v.rst_n = rst_n;
        v.w1 = w1;  v.wa1 = AW'(wa1);  v.wd1 = DW'(wd1);
        v.w2 = w2;  v.wa2 = AW'(wa2);  v.wd2 = DW'(wd2);
        v.r1 = r1;  v.ra1 = AW'(ra1);
        v.r2 = r2;  v.ra2 = AW'(ra2);
        v.e_rd1 = DW'(e_rd1);  v.e_c1 = 2'(e_c1);
        v.e_rd2 = DW'(e_rd2);  v.e_c2 = 2'(e_c2);
        return v;
    endfunction

    task automatic model_step(input vec_t v);
        int a [2];
        bit en [2];
        bit lost;
        if (!v.rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_owner[i] = 1;
                m_coll[i]  = 1'b0;
            end
            for (int r = 0; r < 2; r++) begin
                m_rd[r]  = '0;
                m_col[r] = 2'b00;
            end
            return;
        end
        a[0] = int'(v.ra1);  a[1] = int'(v.ra2);
        en[0] = v.r1;        en[1] = v.r2;
        // Reads observe the state before this edge's writes.
        for (int r = 0; r < 2; r++) begin
            lost = RD_SWITCH && (r == 1) && en[0] && en[1]
                   && (m_owner[a[0]] == m_owner[a[1]]) && (a[0] != a[1]);
            if (!en[r]) begin
                m_col[r] = 2'b00;
            end else if (lost) begin
                m_col[r] = 2'b01;
            end else begin
                m_rd[r]  = m_bank[m_owner[a[r]] - 1][a[r]];
                m_col[r] = {WC && m_coll[a[r]], 1'b0};
            end
        end
        if (v.w1) m_bank[0][v.wa1] = v.wd1;
        if (v.w2) m_bank[1][v.wa2] = v.wd2;
        if (v.w1 && v.w2 && (v.wa1 == v.wa2)) begin
            m_owner[v.wa1] = 1;
            m_coll[v.wa1]  = WC;
        end else begin
            if (v.w1) begin m_owner[v.wa1] = 1; m_coll[v.wa1] = 1'b0; end
            if (v.w2) begin m_owner[v.wa2] = 2; m_coll[v.wa2] = 1'b0; end
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        aresetn = v.rst_n;
        wren1 = v.w1;  wraddr1 = v.wa1;  wrdata1 = v.wd1;
        wren2 = v.w2;  wraddr2 = v.wa2;  wrdata2 = v.wd2;
        rden1 = v.r1;  rdaddr1 = v.ra1;
        rden2 = v.r2;  rdaddr2 = v.ra2;
        model_step(v);
        @(posedge aclk);
        #1;
        $display("%s: rst_n=%b wr1=%b@%0d=%h wr2=%b@%0d=%h rd1=%b@%0d rd2=%b@%0d -> rddata1=%h rdcol1=%b rddata2=%h rdcol2=%b",
                 tag, v.rst_n, v.w1, v.wa1, v.wd1, v.w2, v.wa2, v.wd2,
                 v.r1, v.ra1, v.r2, v.ra2, rddata1, rdcollision1, rddata2, rdcollision2);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag,
                                 input logic [DW-1:0] e_rd1, input logic [1:0] e_c1,
                                 input logic [DW-1:0] e_rd2, input logic [1:0] e_c2);
        check({tag, ".rddata1"},      rddata1,            e_rd1);
        check({tag, ".rdcollision1"}, DW'(rdcollision1),  DW'(e_c1));
        check({tag, ".rddata2"},      rddata2,            e_rd2);
        check({tag, ".rdcollision2"}, DW'(rdcollision2),  DW'(e_c2));
    endtask

    vec_t tbl [$];
    vec_t v;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++)
                m_bank[b][i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_owner[i] = 1;
            m_coll[i]  = 1'b0;
        end
        m_rd[0] = '0;  m_rd[1] = '0;
        m_col[0] = '0; m_col[1] = '0;
        aresetn = 1'b0;
        wren1 = 0; wren2 = 0; rden1 = 0; rden2 = 0;
        wraddr1 = '0; wraddr2 = '0; rdaddr1 = '0; rdaddr2 = '0;
        wrdata1 = '0; wrdata2 = '0;

        //              rst w1 a  d      w2 a  d      r1 a  r2 a   erd1  ec1 erd2  ec2
        tbl.push_back(mk(0, 0, 0, 'h00,  0, 0, 'h00,  0, 0, 0, 0,  'h00, 0, 'h00, 0)); // v0 reset
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 3, 0, 0,  'h00, 0, 'h00, 0)); // v1 unwritten reads 0
        tbl.push_back(mk(1, 1, 2, 'hA5,  0, 0, 'h00,  0, 0, 0, 0,  'h00, 0, 'h00, 0)); // v2
        tbl.push_back(mk(1, 0, 0, 'h00,  1, 2, 'h5A,  0, 0, 0, 0,  'h00, 0, 'h00, 0)); // v3
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 2, 0, 0,  'h5A, 0, 'h00, 0)); // v4 latest write wins
        tbl.push_back(mk(1, 1, 5, 'h11,  1, 5, 'h22,  0, 0, 0, 0,  'h5A, 0, 'h00, 0)); // v5 write collision
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  0, 0, 1, 5,  'h5A, 0, 'h11, 2)); // v6 port 1 wins, flag
        tbl.push_back(mk(1, 0, 0, 'h00,  1, 5, 'h77,  0, 0, 0, 0,  'h5A, 0, 'h11, 0)); // v7 rewrite alone
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 5, 1, 5,  'h77, 0, 'h77, 0)); // v8 flag cleared, same addr
        tbl.push_back(mk(1, 1, 4, 'h33,  0, 0, 'h00,  0, 0, 0, 0,  'h77, 0, 'h77, 0)); // v9
        tbl.push_back(mk(1, 0, 0, 'h00,  1, 4, 'h44,  1, 4, 0, 0,  'h33, 0, 'h77, 0)); // v10 read-during-write old
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 4, 0, 0,  'h44, 0, 'h77, 0)); // v11 new value
        tbl.push_back(mk(1, 1, 0, 'h01,  0, 0, 'h00,  0, 0, 0, 0,  'h44, 0, 'h77, 0)); // v12
        tbl.push_back(mk(1, 1, 1, 'h02,  0, 0, 'h00,  0, 0, 0, 0,  'h44, 0, 'h77, 0)); // v13
`ifdef MPRAM_READ_COLLISION_EN
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 0, 1, 1,  'h01, 0, 'h77, 1)); // v14 bank conflict
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  0, 0, 0, 0,  'h01, 0, 'h77, 0)); // v15 idle holds
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 4, 1, 0,  'h44, 0, 'h01, 0)); // v16 distinct banks
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 4, 1, 2,  'h44, 0, 'h01, 1)); // v17 conflict on bank 2
`else
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 0, 1, 1,  'h01, 0, 'h02, 0)); // v14 no conflict
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  0, 0, 0, 0,  'h01, 0, 'h02, 0)); // v15 idle holds
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 4, 1, 0,  'h44, 0, 'h01, 0)); // v16 distinct banks
        tbl.push_back(mk(1, 0, 0, 'h00,  0, 0, 'h00,  1, 4, 1, 2,  'h44, 0, 'h5A, 0)); // v17 same bank served
`endif

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("v%0d", i));
            check_outputs($sformatf("v%0d", i), tbl[i].e_rd1, tbl[i].e_c1, tbl[i].e_rd2, tbl[i].e_c2);
        end

        // Reset mid-operation: writes/reads in reset are ignored, LVT returns
        // to bank 1 with flags cleared, bank contents survive.
        step(mk(0, 1, 6, 'hEE, 1, 7, 'hDD, 1, 2, 1, 5, 0, 0, 0, 0), "h1");
        check_outputs("h1", 8'h00, 2'b00, 8'h00, 2'b00);
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 6, 0, 0, 0, 0), "h2");
`ifdef MPRAM_READ_COLLISION_EN
        check_outputs("h2", 8'h33, 2'b00, 8'h00, 2'b01);
`else
        check_outputs("h2", 8'h33, 2'b00, 8'h00, 2'b00);
`endif
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0), "h3");
        check_outputs("h3", 8'h33, 2'b00, 8'h11, 2'b00);
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0), "h4");
        check_outputs("h4", 8'h00, 2'b00, 8'h11, 2'b00);

        // Random traffic against the reference model.
        for (int n = 0; n < 250; n++) begin
            v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst_n = ($urandom_range(0, 29) != 0);
            v.w1  = 1'($urandom_range(0, 1));
            v.wa1 = AW'($urandom_range(0, DEPTH - 1));
            v.wd1 = DW'($urandom);
            v.w2  = 1'($urandom_range(0, 1));
            v.wa2 = AW'($urandom_range(0, DEPTH - 1));
            v.wd2 = DW'($urandom);
            v.r1  = 1'($urandom_range(0, 1));
            v.ra1 = AW'($urandom_range(0, DEPTH - 1));
            v.r2  = 1'($urandom_range(0, 1));
            v.ra2 = AW'($urandom_range(0, DEPTH - 1));
            step(v, $sformatf("rnd%0d", n));
            check_outputs($sformatf("rnd%0d", n), m_rd[0], m_col[0], m_rd[1], m_col[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
